// File: rtl/tdm_pkg.sv
// Shared types and constants for the 16-channel TDM transmit path.
package tdm_pkg;

    localparam int NCH   = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCAN
    } state_t;

endpackage

// File: rtl/slot_timer.sv
// Slot sequencer: a dwell counter that paces DWELL cycles per slot and a
// 4-bit slot counter that advances (and wraps 15->0) at each slot end.
module slot_timer
    import tdm_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    output logic [SEL_W-1:0] slot,
    output logic             slot_end,
    output logic             last
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [DW_W-1:0]  r_dwell;
    logic [SEL_W-1:0] r_slot;
    logic             w_slot_end;

    assign w_slot_end = (r_dwell == DW_W'(DWELL - 1));
    assign slot       = r_slot;
    assign slot_end   = w_slot_end;
    assign last       = w_slot_end && (r_slot == SEL_W'(NCH - 1));

    // Advance dwell every running cycle; step the slot when a dwell period ends.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_dwell <= '0;
            r_slot  <= '0;
        end else if (run) begin
            if (w_slot_end) begin
                r_dwell <= '0;
                r_slot  <= r_slot + 1'b1;
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_mux16.sv
// 16-to-1 TDM transmitter: snapshots 16 parallel bits and serialises them
// one per slot with the slot address for the downstream demultiplexer.
module tdm_mux16
    import tdm_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:1] d,
    input  logic        start,
    input  logic        cont,
    input  logic        stop,
    output logic        q,
    output logic [3:0]  sel,
    output logic        valid,
    output logic        frame,
    output logic        done
);

    state_t           r_state;
    logic [NCH-1:0]   r_snap;
    logic             r_frame;
    logic             r_done;

    logic [SEL_W-1:0] w_slot;
    logic             w_slot_end;
    logic             w_last;
    logic             w_scan;
    logic             w_clr;

    assign w_scan = (r_state == SCAN);
    // Counters sit at zero whenever not scanning, so LOAD always hands SCAN slot 0 / dwell 0.
    assign w_clr  = rst || !w_scan;

    slot_timer #(.DWELL(DWELL)) u_timer (
        .clk      (clk),
        .clr      (w_clr),
        .run      (w_scan),
        .slot     (w_slot),
        .slot_end (w_slot_end),
        .last     (w_last)
    );

    // Frame sequencing FSM with snapshot capture and registered frame/done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_snap  <= '0;
            r_frame <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !stop) r_state <= LOAD;
                end
                LOAD: begin
                    if (stop) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= SCAN;
                        r_snap  <= d;
                        r_frame <= 1'b1;
                    end
                end
                SCAN: begin
                    if (stop) begin
                        r_state <= IDLE;
                    end else if (w_slot_end) begin
                        if (w_last) begin
                            if (cont) begin
                                r_snap  <= d;
                                r_frame <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign valid = w_scan;
    assign sel   = w_scan ? w_slot : '0;
    assign q     = w_scan && r_snap[w_slot];
    assign frame = r_frame;
    assign done  = r_done;

endmodule

// File: tb/tb_tdm_mux16.sv
// Bench for tdm_mux16: two instances (DWELL=2 and DWELL=1) share stimulus and
// are checked every cycle against a frame-position reference model.
module tb_tdm_mux16;

    logic        clk;
    logic        rst, start, stop, cont;
    logic [16:1] d;

    logic [1:0]  q_o, valid_o, frame_o, done_o;
    logic [3:0]  sel_o [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tdm_mux16 #(.DWELL(2)) u_a (
        .clk(clk), .rst(rst), .d(d), .start(start), .cont(cont), .stop(stop),
        .q(q_o[0]), .sel(sel_o[0]), .valid(valid_o[0]), .frame(frame_o[0]), .done(done_o[0])
    );

    tdm_mux16 #(.DWELL(1)) u_b (
        .clk(clk), .rst(rst), .d(d), .start(start), .cont(cont), .stop(stop),
        .q(q_o[1]), .sel(sel_o[1]), .valid(valid_o[1]), .frame(frame_o[1]), .done(done_o[1])
    );

    int checks = 0;
    int errors = 0;
    logic armed = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dw_of(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Reference model: a frame is "active" with a position counter 0..16*DW-1.
    typedef struct {
        logic        active;
        logic        loading;
        logic        done;
        int          pos;
        logic [15:0] snap;
    } mdl_t;

    mdl_t m [2];

    function automatic mdl_t step(mdl_t s, int dw);
        mdl_t n;
        n = s;
        n.done = 1'b0;
        if (rst) begin
            n.active = 1'b0; n.loading = 1'b0; n.pos = 0; n.snap = '0;
        end else if ((s.active || s.loading) && stop) begin
            n.active = 1'b0; n.loading = 1'b0; n.pos = 0;
        end else if (s.loading) begin
            n.loading = 1'b0; n.active = 1'b1; n.pos = 0; n.snap = d;
        end else if (s.active) begin
            if (s.pos == 16 * dw - 1) begin
                n.pos = 0;
                if (cont) n.snap = d;
                else begin
                    n.active = 1'b0;
                    n.done = 1'b1;
                end
            end else begin
                n.pos = s.pos + 1;
            end
        end else if (start && !stop) begin
            n.loading = 1'b1;
        end
        return n;
    endfunction

    // Advance the model on each rising edge using the inputs held for that edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) m[i] = step(m[i], dw_of(i));
    end

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                int es;
                logic eq;
                es = m[i].active ? (m[i].pos / dw_of(i)) : 0;
                eq = m[i].active ? m[i].snap[es] : 1'b0;
                check($sformatf("valid[%0d]", i), 32'(valid_o[i]), 32'(m[i].active));
                check($sformatf("sel[%0d]", i),   32'(sel_o[i]),   32'(es));
                check($sformatf("q[%0d]", i),     32'(q_o[i]),     32'(eq));
                check($sformatf("frame[%0d]", i), 32'(frame_o[i]), 32'(m[i].active && m[i].pos == 0));
                check($sformatf("done[%0d]", i),  32'(done_o[i]),  32'(m[i].done));
            end
        end
    end

    // Event monitor: running counts and frame-interval / done-placement invariants.
    int          cyc = 0;
    int          n_valid [2] = '{0, 0};
    int          n_frame [2] = '{0, 0};
    int          n_done  [2] = '{0, 0};
    int          n_ones  [2] = '{0, 0};
    int          done_cyc [2] = '{0, 0};
    int          rise_cyc [2] = '{0, 0};
    int          prev_frame [2] = '{-1, -1};
    logic        prev_valid [2] = '{1'b0, 1'b0};
    logic [15:0] qseq [2] = '{16'h0, 16'h0};

    always @(negedge clk) begin
        cyc++;
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                if (valid_o[i] === 1'b1) begin
                    n_valid[i]++;
                    if (q_o[i] === 1'b1) n_ones[i]++;
                    qseq[i][sel_o[i]] = q_o[i];
                    if (!prev_valid[i]) rise_cyc[i] = cyc;
                end
                if (frame_o[i] === 1'b1) begin
                    n_frame[i]++;
                    if (prev_frame[i] >= 0)
                        check($sformatf("frame_interval[%0d]", i), 32'(cyc - prev_frame[i]), 32'(16 * dw_of(i)));
                    prev_frame[i] = cyc;
                end
                if (valid_o[i] !== 1'b1) prev_frame[i] = -1;
                if (done_o[i] === 1'b1) begin
                    n_done[i]++;
                    done_cyc[i] = cyc;
                    check($sformatf("done_after_valid[%0d]", i), 32'(prev_valid[i]), 32'd1);
                end
                prev_valid[i] = (valid_o[i] === 1'b1);
            end
        end
    end

    int base_v [2], base_f [2], base_d [2], base_o [2];
    int qexp [16] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic take_base();
        for (int i = 0; i < 2; i++) begin
            base_v[i] = n_valid[i];
            base_f[i] = n_frame[i];
            base_d[i] = n_done[i];
            base_o[i] = n_ones[i];
        end
    endtask

    task automatic wait_sel(int i, int k, string name);
        int t;
        t = 0;
        while (!(valid_o[i] === 1'b1 && sel_o[i] == 4'(k)) && t < 300) begin
            tick(1);
            t++;
        end
        check(name, 32'(t < 300), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int drops;
        int t;
        rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; d = '0;
        tick(2);
        armed = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_sel",   32'(sel_o[0]), 32'd0);
        check("reset_q",     32'(q_o), 32'd0);
        check("reset_done",  32'(done_o), 32'd0);

        // Reset in the middle of a frame
        take_base();
        d = 16'hFFFF;
        pulse_start();
        wait_sel(0, 5, "wait_slot5");
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_sel",   32'(sel_o[0]), 32'd0);
        check("midrst_q",     32'(q_o), 32'd0);
        check("midrst_done",  32'(done_o), 32'd0);
        tick(40);
        check("midrst_stays_idle", 32'(valid_o), 32'd0);
        check("midrst_no_done_a", 32'(n_done[0] - base_d[0]), 32'd0);
        check("midrst_no_done_b", 32'(n_done[1] - base_d[1]), 32'd0);

        // Single frame with a known pattern
        take_base();
        d = 16'hA5C3;
        cont = 1'b0;
        pulse_start();
        tick(40);
        check("single_valid_len_a", 32'(n_valid[0] - base_v[0]), 32'd32);
        check("single_valid_len_b", 32'(n_valid[1] - base_v[1]), 32'd16);
        check("single_frames_a",    32'(n_frame[0] - base_f[0]), 32'd1);
        check("single_done_a",      32'(n_done[0] - base_d[0]), 32'd1);
        check("single_done_b",      32'(n_done[1] - base_d[1]), 32'd1);
        check("single_done_pos_a",  32'(done_cyc[0] - rise_cyc[0]), 32'd32);
        for (int s = 0; s < 16; s++)
            check($sformatf("single_q_slot%0d", s), 32'(qseq[0][s]), 32'(qexp[s]));
        check("single_qseq_b", 32'(qseq[1]), 32'hA5C3);

        // Snapshot isolation: d drops to zero during slot 3
        take_base();
        d = 16'hFFFF;
        pulse_start();
        wait_sel(0, 3, "wait_slot3");
        d = 16'h0000;
        tick(40);
        check("snap_ones_a", 32'(n_ones[0] - base_o[0]), 32'd32);
        check("snap_ones_b", 32'(n_ones[1] - base_o[1]), 32'd16);

        // Continuous scanning with a pattern change before the next boundary
        take_base();
        cont = 1'b1;
        d = 16'h0001;
        pulse_start();
        tick(3);
        d = 16'h8000;
        drops = 0;
        for (int c = 0; c < 60; c++) begin
            tick(1);
            if (valid_o !== 2'b11) drops++;
            if (done_o !== 2'b00) drops++;
        end
        check("cont_no_drop_no_done", 32'(drops), 32'd0);
        check("cont_frames_b_ge4", 32'(n_frame[1] - base_f[1] >= 4), 32'd1);
        check("cont_qseq_b", 32'(qseq[1]), 32'h8000);
        cont = 1'b0;
        tick(40);
        check("cont_end_done_a", 32'(n_done[0] - base_d[0]), 32'd1);
        check("cont_qseq_a", 32'(qseq[0]), 32'h8000);

        // Abort at slot 7
        take_base();
        d = 16'h5A5A;
        pulse_start();
        wait_sel(0, 7, "wait_slot7");
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(valid_o), 32'd0);
        tick(5);
        check("abort_no_done_a", 32'(n_done[0] - base_d[0]), 32'd0);
        check("abort_no_done_b", 32'(n_done[1] - base_d[1]), 32'd0);

        // start and stop together in IDLE
        take_base();
        start = 1'b1;
        stop = 1'b1;
        tick(4);
        start = 1'b0;
        stop = 1'b0;
        tick(3);
        check("startstop_no_valid", 32'(n_valid[0] - base_v[0] + n_valid[1] - base_v[1]), 32'd0);

        // start held high through a frame and its done pulse
        take_base();
        d = 16'h1234;
        start = 1'b1;
        t = 0;
        while (n_done[0] == base_d[0] && t < 200) begin
            tick(1);
            t++;
        end
        check("held_done_seen", 32'(t < 200), 32'd1);
        check("held_frames_a", 32'(n_frame[0] - base_f[0]), 32'd1);
        tick(3);
        check("held_restart_gap", 32'(rise_cyc[0] - done_cyc[0]), 32'd2);
        start = 1'b0;
        tick(80);

        // Randomised traffic
        for (int c = 0; c < 500; c++) begin
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 31) == 0) cont = 1'($urandom_range(0, 1));
            d     = 16'($urandom);
            rst   = ($urandom_range(0, 249) == 0);
            tick(1);
        end
        start = 1'b0; stop = 1'b0; cont = 1'b0; rst = 1'b0;
        tick(80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
